// File: rtl/sumador_serial.sv
// Bit-serial N-bit adder: one full adder reused N times, LSB first.
// The carry lives in a flip-flop between cycles and the sum bits are
// reassembled in a result shift register. All outputs are registered.

// Single-bit full adder; the only arithmetic in the serial datapath.
module sumador_serial_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module sumador_serial #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         INICIO,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         AE,
    output logic [N-1:0] SUMA,
    output logic         AS,
    output logic         OCUPADO,
    output logic         LISTO
);
    // Counter must be able to hold N-1; N+1 keeps width >= 1 for N=1.
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUMANDO = 2'd1,
        FIN     = 2'd2
    } state_t;

    state_t        state_q;
    logic [N-1:0]  opa_q;
    logic [N-1:0]  opb_q;
    logic [N-1:0]  res_q;
    logic [N-1:0]  res_d;
    logic          carry_q;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  suma_q;
    logic          as_q;
    logic          ocupado_q;
    logic          listo_q;

    logic          fa_s;
    logic          fa_c;

    sumador_serial_fa u_fa (
        .a_i (opa_q[0]),
        .b_i (opb_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // Result shifts right with the new sum bit entering at the MSB.
    // The N+1-bit concatenation keeps the slice legal when N=1.
    logic [N:0] res_ext;
    always_comb begin
        res_ext = {fa_s, res_q};
        res_d   = res_ext[N:1];
    end

    // Control FSM and serial datapath; a start is accepted from IDLE or FIN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            suma_q    <= '0;
            as_q      <= 1'b0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    listo_q <= 1'b0;
                    if (INICIO) begin
                        opa_q     <= A;
                        opb_q     <= B;
                        carry_q   <= AE;
                        res_q     <= '0;
                        cnt_q     <= '0;
                        ocupado_q <= 1'b1;
                        state_q   <= SUMANDO;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                SUMANDO: begin
                    // INICIO is deliberately not looked at here.
                    res_q   <= res_d;
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        suma_q    <= res_d;
                        as_q      <= fa_c;
                        ocupado_q <= 1'b0;
                        listo_q   <= 1'b1;
                        state_q   <= FIN;
                    end
                end
                default: begin
                    ocupado_q <= 1'b0;
                    listo_q   <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign SUMA    = suma_q;
    assign AS      = as_q;
    assign OCUPADO = ocupado_q;
    assign LISTO   = listo_q;
endmodule

// File: tb/tb_sumador_serial.sv
// Self-checking bench for sumador_serial (N=8). Expected completions are
// queued when a start is driven; a monitor records every LISTO cycle and
// each scenario pairs them up.
module tb_sumador_serial;
    localparam int N = 8;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [N-1:0] suma;
        logic         as_;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         inicio = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         ae = 1'b0;
    logic [N-1:0] suma;
    logic         as_o;
    logic         ocupado;
    logic         listo;

    int total = 0;
    int bad   = 0;
    logic [31:0] cyc = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    sumador_serial #(.N(N)) dut (
        .CLK     (clk),
        .RST     (rst),
        .INICIO  (inicio),
        .A       (a),
        .B       (b),
        .AE      (ae),
        .SUMA    (suma),
        .AS      (as_o),
        .OCUPADO (ocupado),
        .LISTO   (listo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completion, sampled away from the active edge.
    always @(negedge clk) begin
        if (listo) obs_q.push_back('{cyc: cyc, suma: suma, as_: as_o});
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one start at the next edge (edge 0) and queue the golden result.
    task automatic start(input logic [N-1:0] aa, input logic [N-1:0] bb,
                         input logic cin, output logic [31:0] e0);
        logic [N:0] full;
        a = aa; b = bb; ae = cin; inicio = 1'b1;
        tick(1);
        inicio = 1'b0;
        e0 = cyc;
        full = {1'b0, aa} + {1'b0, bb} + {{N{1'b0}}, cin};
        exp_q.push_back('{cyc: e0 + 8, suma: full[N-1:0], as_: full[N]});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        total++;
        if ({suma, as_o, ocupado, listo} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got suma=%h as=%b ocu=%b listo=%b want 00 0 0 0",
                     suma, as_o, ocupado, listo);
        end
        tick(6);
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL reset_idle_listo got %0d pulses want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_basic();
        logic [31:0] e0;
        ev_t o, e;
        start(8'h2D, 8'h1C, 1'b0, e0);
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick(1);
            total++;
            if (ocupado !== (k < 8) || listo !== (k == 8)) begin
                bad++;
                $display("FAIL basic_timing edge=%0d got ocu=%b listo=%b want ocu=%b listo=%b",
                         k, ocupado, listo, k < 8, k == 8);
            end
        end
        tick(2);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            total++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                bad++;
                $display("FAIL basic_count got obs=%0d want exp=%0d", obs_q.size(), exp_q.size());
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL basic_result got cyc=%0d suma=%h as=%b want cyc=%0d suma=%h as=%b",
                         o.cyc, o.suma, o.as_, e.cyc, e.suma, e.as_);
            end
        end
    endtask

    task automatic test_carry();
        logic [31:0] e0;
        ev_t o, e;
        logic [N-1:0] ta [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [N-1:0] tb [3] = '{8'h01, 8'hFF, 8'h00};
        logic         tc [3] = '{1'b0, 1'b1, 1'b1};
        for (int t = 0; t < 3; t++) begin
            start(ta[t], tb[t], tc[t], e0);
            tick(10);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            total++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                bad++;
                $display("FAIL carry_count got obs=%0d want exp=%0d", obs_q.size(), exp_q.size());
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL carry_result got cyc=%0d suma=%h as=%b want cyc=%0d suma=%h as=%b",
                         o.cyc, o.suma, o.as_, e.cyc, e.suma, e.as_);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [31:0] e0;
        ev_t o, e;
        start(8'h10, 8'h20, 1'b0, e0);
        tick(2);
        a = 8'hAA; b = 8'h55; inicio = 1'b1;
        tick(1);
        inicio = 1'b0;
        tick(12);
        total++;
        if (ocupado !== 1'b0) begin
            bad++;
            $display("FAIL busy_second_start got ocu=%b want 0", ocupado);
        end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            total++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                bad++;
                $display("FAIL busy_count got obs=%0d want exp=%0d", obs_q.size(), exp_q.size());
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL busy_result got cyc=%0d suma=%h as=%b want cyc=%0d suma=%h as=%b",
                         o.cyc, o.suma, o.as_, e.cyc, e.suma, e.as_);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e0;
        logic [31:0] e1;
        ev_t o, e;
        start(8'h01, 8'h02, 1'b0, e0);
        tick(8);
        // In the LISTO cycle: a start here is taken at edge 9.
        start(8'h80, 8'h80, 1'b0, e1);
        total++;
        if (e1 !== e0 + 9) begin
            bad++;
            $display("FAIL b2b_capture_edge got %0d want %0d", e1 - e0, 9);
        end
        tick(11);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            total++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                bad++;
                $display("FAIL b2b_count got obs=%0d want exp=%0d", obs_q.size(), exp_q.size());
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL b2b_result got cyc=%0d suma=%h as=%b want cyc=%0d suma=%h as=%b",
                         o.cyc, o.suma, o.as_, e.cyc, e.suma, e.as_);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e0;
        ev_t o, e;
        start(8'h7F, 8'h01, 1'b0, e0);
        tick(4);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({suma, as_o, ocupado, listo} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midrst_outputs got suma=%h as=%b ocu=%b listo=%b want 00 0 0 0",
                     suma, as_o, ocupado, listo);
        end
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(10);
        total++;
        if (obs_q.size() != 0) begin
            bad++;
            $display("FAIL midrst_listo got %0d pulses want 0", obs_q.size());
        end
        obs_q.delete();
        start(8'h7F, 8'h01, 1'b0, e0);
        tick(10);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            total++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                bad++;
                $display("FAIL midrst_count got obs=%0d want exp=%0d", obs_q.size(), exp_q.size());
                break;
            end
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin
                bad++;
                $display("FAIL midrst_result got cyc=%0d suma=%h as=%b want cyc=%0d suma=%h as=%b",
                         o.cyc, o.suma, o.as_, e.cyc, e.suma, e.as_);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
